// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline hazard unit for a 5-stage in-order core.
//   Handles three hazard sources:
//     - load-use stalls, inserted as a bubble in ID/EX;
//     - multi-cycle MDU ops, which freeze the front of the pipe for MDU_LAT cycles;
//     - taken-branch flushes, which have the highest priority.
//   Keeps saturating performance counters for stall cycles and branch flushes.
//
// Parameters
//   MDU_LAT  total EX-stage cycles of a mul/div op (2..15)
//   CNT_W    width of the performance counters
//
// Ports
//   clk_i                               clock; all state updates on its rising edge
//   rst_i                               synchronous reset, active low
//   IFID_rs_i, IFID_rt_i                source register fields of the ID instruction
//   IDEX_rt_i, IDEX_memread_i           destination and load flag of the EX instruction
//   mdu_start_i                         level; a mul/div op occupies ID/EX
//   branch_taken_i                      the branch in MEM resolved taken
//   pc_write_o, ifid_write_o,
//   idex_write_o                        pipeline register write enables
//   bubble_sel_o                        1 selects all-zero ID control
//   ifid_flush_o, idex_flush_o,
//   exmem_flush_o                       clear the named pipeline register
//   mdu_busy_o, mdu_done_o              MDU stall active / MDU release pulse
//   stall_cnt_o, flush_cnt_o            saturating stall-cycle / branch-flush counters
module hazard_stall_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic             IDEX_memread_i,
  input  logic             mdu_start_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_write_o,
  output logic             bubble_sel_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             mdu_busy_o,
  output logic             mdu_done_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MDU_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             load_use;

  // A load into $zero never creates a real dependency.
  assign load_use = IDEX_memread_i && (IDEX_rt_i != 5'd0) &&
                    ((IDEX_rt_i == IFID_rs_i) || (IDEX_rt_i == IFID_rt_i));

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_write_o  = 1'b1;
    bubble_sel_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    mdu_busy_o    = 1'b0;
    mdu_done_o    = 1'b0;
    // Outputs are forced to their idle values while reset is held.
    if (rst_i) begin
      if (branch_taken_i) begin
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
      end else begin
        unique case (state)
          RUN: begin
            if (mdu_start_i) begin
              pc_write_o    = 1'b0;
              ifid_write_o  = 1'b0;
              idex_write_o  = 1'b0;
              exmem_flush_o = 1'b1;
              mdu_busy_o    = 1'b1;
            end else if (load_use) begin
              pc_write_o   = 1'b0;
              ifid_write_o = 1'b0;
              bubble_sel_o = 1'b1;
            end
          end
          MDU_WAIT: begin
            // Load-use is irrelevant here: the front of the pipe is frozen.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_flush_o = 1'b1;
            mdu_busy_o    = 1'b1;
          end
          MDU_DONE: begin
            mdu_done_o = 1'b1;
            if (load_use) begin
              pc_write_o   = 1'b0;
              ifid_write_o = 1'b0;
              bubble_sel_o = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (branch_taken_i) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        unique case (state)
          RUN: begin
            if (mdu_start_i) begin
              // The RUN cycle that sees the start is the first stall cycle.
              state <= MDU_WAIT;
              cnt   <= 4'(MDU_LAT - 1);
            end
          end
          MDU_WAIT: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= MDU_DONE;
          end
          MDU_DONE: state <= RUN;
          default:  state <= RUN;
        endcase
      end
      if (!pc_write_o && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (branch_taken_i && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       idex_memread, mdu_start, branch_taken;

  logic        pc_write, ifid_write, idex_write, bubble_sel;
  logic        ifid_flush, idex_flush, exmem_flush, mdu_busy, mdu_done;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_idex_write, s_bubble_sel;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_mdu_busy, s_mdu_done;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs_i(ifid_rs), .IFID_rt_i(ifid_rt),
    .IDEX_rt_i(idex_rt), .IDEX_memread_i(idex_memread),
    .mdu_start_i(mdu_start), .branch_taken_i(branch_taken),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .idex_write_o(idex_write),
    .bubble_sel_o(bubble_sel),
    .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush), .exmem_flush_o(exmem_flush),
    .mdu_busy_o(mdu_busy), .mdu_done_o(mdu_done),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // Narrow-counter instance for saturation; shares all stimulus.
  hazard_stall_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst),
    .IFID_rs_i(ifid_rs), .IFID_rt_i(ifid_rt),
    .IDEX_rt_i(idex_rt), .IDEX_memread_i(idex_memread),
    .mdu_start_i(mdu_start), .branch_taken_i(branch_taken),
    .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .idex_write_o(s_idex_write),
    .bubble_sel_o(s_bubble_sel),
    .ifid_flush_o(s_ifid_flush), .idex_flush_o(s_idex_flush), .exmem_flush_o(s_exmem_flush),
    .mdu_busy_o(s_mdu_busy), .mdu_done_o(s_mdu_done),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  // {pc_write, ifid_write, idex_write, bubble_sel, ifid_flush, idex_flush, exmem_flush, busy, done}
  localparam logic [8:0] DEF  = 9'b111_0_000_00;
  localparam logic [8:0] LU   = 9'b001_1_000_00;
  localparam logic [8:0] BR   = 9'b111_0_111_00;
  localparam logic [8:0] MB   = 9'b000_0_001_10;
  localparam logic [8:0] DN   = 9'b111_0_000_01;
  localparam logic [8:0] DNLU = 9'b001_1_000_01;

  typedef struct {
    logic        rst, memread;
    logic [4:0]  idex_rt, rs, rt;
    logic        mdu, br;
    logic [8:0]  exp_o;
    logic        chk_cnt;
    logic [15:0] exp_s, exp_f;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] irt,
                              input logic [4:0] rs_v, input logic [4:0] rt_v,
                              input logic m, input logic b, input logic [8:0] o,
                              input logic c, input logic [15:0] s, input logic [15:0] f);
    vec_t v;
    v.rst = r; v.memread = mr; v.idex_rt = irt; v.rs = rs_v; v.rt = rt_v;
    v.mdu = m; v.br = b; v.exp_o = o; v.chk_cnt = c; v.exp_s = s; v.exp_f = f;
    return v;
  endfunction

  task automatic drive(input logic r, input logic mr, input logic [4:0] irt,
                       input logic [4:0] rs_v, input logic [4:0] rt_v,
                       input logic m, input logic b);
    rst = r; idex_memread = mr; idex_rt = irt; ifid_rs = rs_v; ifid_rt = rt_v;
    mdu_start = m; branch_taken = b;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [8:0] outs;
  assign outs = {pc_write, ifid_write, idex_write, bubble_sel,
                 ifid_flush, idex_flush, exmem_flush, mdu_busy, mdu_done};

  initial begin
    vec_t e;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // reset gating and first counter values
    tbl.push_back(mk(0,1,8,8,0,1,1, DEF, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0, DEF, 1, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 0, 0));
    // load-use on rs, $zero load, load-use on rt, no-load match
    tbl.push_back(mk(1,1,8,8,0,0,0, LU,  1, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 1, 0));
    tbl.push_back(mk(1,1,0,3,0,0,0, DEF, 1, 1, 0));
    tbl.push_back(mk(1,1,5,1,5,0,0, LU,  1, 1, 0));
    tbl.push_back(mk(1,0,5,5,0,0,0, DEF, 1, 2, 0));
    // branch beats load-use
    tbl.push_back(mk(1,1,8,8,0,0,1, BR,  1, 2, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 2, 1));
    // MDU op, start held 5 cycles: 4 busy, 1 done, back to RUN
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 2, 1));
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 3, 1));
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 4, 1));
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 5, 1));
    tbl.push_back(mk(1,0,0,0,0,1,0, DN,  1, 6, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 6, 1));
    // load-use ignored in MDU_WAIT, honoured in MDU_DONE
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 6, 1));
    tbl.push_back(mk(1,1,8,8,0,0,0, MB,  1, 7, 1));
    tbl.push_back(mk(1,1,8,8,0,0,0, MB,  1, 8, 1));
    tbl.push_back(mk(1,1,8,8,0,0,0, MB,  1, 9, 1));
    tbl.push_back(mk(1,1,8,8,0,1,0, DNLU,1, 10, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 11, 1));
    // branch in MDU_WAIT cycle 2 aborts, no done pulse
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 11, 1));
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 12, 1));
    tbl.push_back(mk(1,0,0,0,0,1,1, BR,  1, 13, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 13, 2));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 13, 2));
    // reset mid-MDU_WAIT aborts, no done pulse
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 13, 2));
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 14, 2));
    tbl.push_back(mk(0,0,0,0,0,1,0, DEF, 1, 15, 2));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 0, 0));
    // branch in MDU_DONE suppresses done; branch beats MDU start in RUN
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 1, 0));
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 2, 0));
    tbl.push_back(mk(1,0,0,0,0,1,0, MB,  1, 3, 0));
    tbl.push_back(mk(1,0,0,0,0,1,1, BR,  1, 4, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 4, 1));
    tbl.push_back(mk(1,0,0,0,0,1,1, BR,  1, 4, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0, DEF, 1, 4, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].memread, tbl[i].idex_rt, tbl[i].rs, tbl[i].rt,
            tbl[i].mdu, tbl[i].br);
      sb.push_back(tbl[i]);
      #1;
      e = sb.pop_front();
      check($sformatf("row%0d outputs", i), {7'd0, outs}, {7'd0, e.exp_o});
      if (e.chk_cnt) begin
        check($sformatf("row%0d stall_cnt", i), stall_cnt, e.exp_s);
        check($sformatf("row%0d flush_cnt", i), flush_cnt, e.exp_f);
      end
    end

    // saturation: 20 load-use cycles, then 20 branch cycles, then one reset edge
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
    end
    #1;
    check("sat stall_cnt w16", stall_cnt, 16'd20);
    check("sat stall_cnt w4", {12'd0, s_stall_cnt}, 16'd15);
    check("sat flush_cnt w4 idle", {12'd0, s_flush_cnt}, 16'd0);
    check("sat lu pc_write", {15'd0, s_pc_write}, 16'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
    end
    #1;
    check("sat flush_cnt w16", flush_cnt, 16'd20);
    check("sat flush_cnt w4", {12'd0, s_flush_cnt}, 16'd15);
    check("sat stall_cnt w16 held", stall_cnt, 16'd20);
    check("sat stall_cnt w4 held", {12'd0, s_stall_cnt}, 16'd15);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("rst stall_cnt w4", {12'd0, s_stall_cnt}, 16'd0);
    check("rst flush_cnt w4", {12'd0, s_flush_cnt}, 16'd0);
    check("rst stall_cnt w16", stall_cnt, 16'd0);
    check("rst flush_cnt w16", flush_cnt, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
